// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS CPU: next-PC source
// encodings, the default fetch/reset address and the PC-stage states.
package cpu_pkg;

  // Next-PC source selects driven by the controller
  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JREG   = 2'b11;

  // Default reset PC, also the base of the instruction-memory window
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int unsigned DEFAULT_IM_WORDS = 1024;

  // PC-stage states
  typedef enum logic [0:0] {
    PC_ST_RUN  = 1'b0,
    PC_ST_HALT = 1'b1
  } pc_state_e;

  // Branch displacement: signed word offset turned into a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    branch_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Jump target: region bits from the link address, index shifted to bytes
  function automatic logic [31:0] jump_target(input logic [31:0] link,
                                              input logic [25:0] index);
    jump_target = {link[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_npc.sv
// Combinational next-PC computation. Selects between the sequential,
// branch, jump and jump-register paths. All arithmetic is modulo 2^32.
module npc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] next_pc,
  output logic [31:0] seq_pc
);

  logic [31:0] branch_pc;

  // Sequential address doubles as the link value for jal/jalr
  assign seq_pc    = pc + 32'd4;
  assign branch_pc = seq_pc + branch_offset(imm16);

  // Source mux for the next fetch address
  always_comb begin
    next_pc = seq_pc;
    case (npc_sel)
      NPC_SEQ:    next_pc = seq_pc;
      NPC_BRANCH: next_pc = br_taken ? branch_pc : seq_pc;
      NPC_JUMP:   next_pc = jump_target(seq_pc, imm26);
      NPC_JREG:   next_pc = ra;
      default:    next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds the fetch address, advances it from the
// selected next-PC source, and halts when the target leaves the
// instruction-memory window. Also counts accepted advances.
// Optional feature macro: PC_ALIGN_CHECK_EN -- when defined, a misaligned
// jump-register target halts the stage and sets the sticky pc_err flag;
// when undefined, the low two target bits are dropped and pc_err is 0.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IM_WORDS = DEFAULT_IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        pc_err,
  output logic [31:0] retired
);

  localparam logic [0:0] S_RUN  = PC_ST_RUN;
  localparam logic [0:0] S_HALT = PC_ST_HALT;

  // Window bounds in 33 bits so a window ending at 2^32 cannot wrap
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(IM_WORDS) << 2);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] retired_reg, retired_next;
  logic [0:0]  state_reg, state_next;
  logic        err_reg, err_next;

  logic [31:0] npc_raw;
  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        misaligned;
  logic        in_window;
  logic        accept;

  npc u_npc (
    .pc       (pc_reg),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .ra       (ra),
    .next_pc  (npc_raw),
    .seq_pc   (seq_pc)
  );

`ifdef PC_ALIGN_CHECK_EN
  // Only a register target can be misaligned; PC-relative paths stay aligned
  assign target     = npc_raw;
  assign misaligned = |npc_raw[1:0];
`else
  // Drop the byte-offset bits so a register target always lands on a word
  assign target     = {npc_raw[31:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  // Candidate target must sit inside [RESET_PC, RESET_PC + 4*IM_WORDS)
  assign in_window = ({1'b0, target} >= WIN_LO) && ({1'b0, target} < WIN_HI);
  assign accept    = in_window && !misaligned;

  // Next-state logic: advance on accepted target, halt on a rejected one
  always_comb begin
    pc_next      = pc_reg;
    retired_next = retired_reg;
    state_next   = state_reg;
    err_next     = err_reg;
    if (state_reg == S_RUN && en) begin
      if (accept) begin
        pc_next      = target;
        retired_next = retired_reg + 32'd1;
      end else begin
        state_next = S_HALT;
        err_next   = err_reg | misaligned;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg      <= RESET_PC;
      retired_reg <= 32'd0;
      state_reg   <= S_RUN;
      err_reg     <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
      state_reg   <= state_next;
      err_reg     <= err_next;
    end
  end

  assign pc       = pc_reg;
  assign pc_plus4 = seq_pc;
  assign halted   = (state_reg == S_HALT);
  assign retired  = retired_reg;
`ifdef PC_ALIGN_CHECK_EN
  assign pc_err   = err_reg;
`else
  assign pc_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the stimulus process queues the expected
// post-edge state of each transaction, and a monitor on the falling edge
// pops and compares it against the DUT outputs.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] imm26 = 26'h0;
  logic [31:0] ra = 32'h0;
  logic [31:0] pc, pc_plus4, retired;
  logic        halted, pc_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        halted;
    logic        err;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];

  pc_unit dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .ra       (ra),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .halted   (halted),
    .pc_err   (pc_err),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare one queued expectation per falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %-14s pc=%h pc_plus4=%h halted=%0d pc_err=%0d retired=%0d",
               e.name, pc, pc_plus4, halted, pc_err, retired);
      chk({e.name, ".pc"},       pc,               e.pc);
      chk({e.name, ".pc_plus4"}, pc_plus4,         e.pc + 32'd4);
      chk({e.name, ".halted"},   {31'd0, halted},  {31'd0, e.halted});
      chk({e.name, ".pc_err"},   {31'd0, pc_err},  {31'd0, e.err});
      chk({e.name, ".retired"},  retired,          e.ret);
    end
  end

  task automatic push(input string name, input logic [31:0] p, input logic h,
                      input logic er, input logic [31:0] r);
    exp_t e;
    e.name = name; e.pc = p; e.halted = h; e.err = er; e.ret = r;
    exp_q.push_back(e);
  endtask

  // One clocked transaction: drive on falling edge, expect after rising edge
  task automatic step(input string name, input logic e_en, input logic [1:0] sel,
                      input logic br, input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] r, input logic [31:0] p, input logic h,
                      input logic er, input logic [31:0] ret);
    @(negedge clk);
    en = e_en; npc_sel = sel; br_taken = br; imm16 = i16; imm26 = i26; ra = r;
    @(posedge clk);
    push(name, p, h, er, ret);
  endtask

  // Assert reset mid-cycle; reset values are expected before any rising edge
  task automatic mid_reset(input string name);
    @(posedge clk);
    #2 reset = 1'b0;
    en = 1'b0;
    #1 push(name, 32'h3000, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Power-on reset: check reset values while reset is still held
    @(posedge clk);
    #1 push("reset", 32'h3000, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch
    step("seq1", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 0, 1);
    step("seq2", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 0, 2);
    step("seq3", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 0, 0, 3);
    step("seq4", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3010, 0, 0, 4);

    // Branches from 0x3008
    step("jr3008a", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3008, 32'h3008, 0, 0, 5);
    step("br_taken", 1, 2'b01, 1, 16'hFFFE, 26'h0, 32'h0, 32'h3004, 0, 0, 6);
    step("jr3008b", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3008, 32'h3008, 0, 0, 7);
    step("br_not", 1, 2'b01, 0, 16'hFFFE, 26'h0, 32'h0, 32'h300C, 0, 0, 8);

    // Jump from 0x3010 (monitor sees pc_plus4=0x3014 before the jump edge)
    step("jr3010", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3010, 32'h3010, 0, 0, 9);
    step("jump", 1, 2'b10, 0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 0, 0, 10);

    // Stall with an out-of-window jump presented: nothing moves
    step("stall1", 0, 2'b10, 0, 16'h0, 26'h0, 32'h0, 32'h3040, 0, 0, 10);
    step("stall2", 0, 2'b10, 0, 16'h0, 26'h0, 32'h0, 32'h3040, 0, 0, 10);
    step("stall3", 0, 2'b10, 0, 16'h0, 26'h0, 32'h0, 32'h3040, 0, 0, 10);

    // Last word of the window accepted, then falling off its top halts
    step("jr_top", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3FFC, 32'h3FFC, 0, 0, 11);
    step("seq_off", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3FFC, 1, 0, 11);
    step("halt_hold", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3000, 32'h3FFC, 1, 0, 11);
    mid_reset("rst_halt");

    // Lower window boundary
    step("jr_base", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3000, 32'h3000, 0, 0, 1);
    step("jr_below", 1, 2'b11, 0, 16'h0, 26'h0, 32'h2FFC, 32'h3000, 1, 0, 1);
    step("halt_hold2", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 1, 0, 1);
    mid_reset("rst2");

    // Far out-of-range register target (no wrap pass)
    step("jr_ffff", 1, 2'b11, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h3000, 1, 0, 0);
    mid_reset("rst3");

    // Misaligned register target
`ifdef PC_ALIGN_CHECK_EN
    step("jr_misal", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3006, 32'h3000, 1, 1, 0);
    step("err_sticky", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 1, 1, 0);
`else
    step("jr_misal", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3006, 32'h3004, 0, 0, 1);
    step("after_misal", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 0, 2);
`endif
    mid_reset("rst_final");

    // Drain the scoreboard with a bounded wait
    begin
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
        @(posedge clk);
        cyc++;
      end
      @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the single-cycle MIPS CPU: holds the current fetch address, drives it to the instruction memory, and computes the next address each cycle from the sequential, branch, jump and jump-register paths selected by the controller. It also tracks a halted state when control leaves the instruction-memory window. A committed-instruction counter supports bench and debug use.

## Interface
- RESET_PC, 32'h0000_3000, fetch address loaded on reset; base of IM window
- IM_WORDS, 1024, number of 32-bit words in IM; window is [RESET_PC, RESET_PC + 4*IM_WORDS)
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = stall, PC holds
- npc_sel  in  2  next-PC source: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JREG
- br_taken  in  1  branch condition result, used only when npc_sel = BRANCH
- imm16  in  16  branch offset, word units, signed
- imm26  in  26  jump index
- ra  in  32  jump-register target (rs value)
- pc  out  32  current fetch address to IM
- pc_plus4  out  32  pc + 4, link value for jal/jalr
- halted  out  1  1 while in HALT state
- pc_err  out  1  sticky misaligned-target flag (see Configuration)
- retired  out  32  count of accepted PC advances

## Operation
- States: RUN, HALT. Reset enters RUN.
- Next-PC (combinational, mod 2^32):
  - SEQ: pc + 4
  - BRANCH: br_taken ? pc + 4 + (sext(imm16) << 2) : pc + 4
  - JUMP: {pc_plus4[31:28], imm26, 2'b00}
  - JREG: ra
- RUN, en = 1: if npc is inside IM window and aligned, pc <= npc, retired <= retired + 1; otherwise pc holds, state -> HALT, retired not incremented.
- RUN, en = 0: everything holds; npc_sel and data inputs ignored.
- HALT: pc, retired hold; halted = 1; only reset exits.
- Window check: npc >= RESET_PC and npc < RESET_PC + 4*IM_WORDS, unsigned compare in 33 bits (no wrap false-pass).
- retired wraps 0xFFFF_FFFF -> 0.

## Timing
- Reset (asynchronous assert, any time incl. mid-stall or HALT): pc = RESET_PC, pc_plus4 = RESET_PC + 4, halted = 0, pc_err = 0, retired = 0, state RUN.
- Reset deassertion is synchronised by the integrating top; the block samples nothing while reset = 0.
- pc changes only on a rising clk edge; one-cycle latency from inputs to new pc.
- pc_plus4 is combinational from pc, valid in the same cycle.
- halted rises on the edge that rejects the target; pc shows the last valid address.
- Simultaneous en = 1 and out-of-window target: HALT wins, no counter increment.

## Configuration
- PC_ALIGN_CHECK_EN defined: an npc with [1:0] != 0 (JREG only) causes HALT and sets pc_err (sticky until reset), same cycle as halted.
- Undefined: JREG target low two bits forced to 0 before window check; pc_err tied 0; port kept.

## Structure
- Shared package cpu_pkg: npc_sel encodings (NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_JREG), default RESET_PC constant, state enum.
- Sub-module npc: pure combinational next-PC computation from pc, npc_sel, br_taken, imm16, imm26, ra; pc_unit keeps registers, window/alignment check and state machine.

## Test plan
- Reset then 4 cycles en=1, SEQ -> pc 0x3000, 0x3004, 0x3008, 0x300C, 0x3010; retired = 4.
- pc=0x3008, BRANCH, br_taken=1, imm16=0xFFFE -> pc 0x3004; same with br_taken=0 -> 0x300C.
- pc=0x3010, JUMP, imm26=0x0000C10 -> pc 0x3040; pc_plus4 before edge = 0x3014.
- en=0 for 3 cycles with JUMP asserted -> pc and retired unchanged; JREG ra=0x2FFC -> halted=1, pc holds, further edges ignored, reset -> pc 0x3000, halted 0.
- JREG ra=0x3006: with PC_ALIGN_CHECK_EN -> halted=1, pc_err=1; without -> pc 0x3004, pc_err 0.
- Reset asserted mid-cycle while halted -> outputs return to reset values immediately, without a clk edge.
